// File: rtl/return_sequencer.sv
// Program-counter and call/return sequencer for the Forth core.
// Fetches instruction words, forwards data ops, and drives push/pop strobes to the return stack.
module return_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int RS_DEPTH   = 1024,
  parameter int RESET_PC   = 0
) (
  input  logic                          write_clock,
  input  logic                          reset,
  input  logic                          hold,
  input  logic [DATA_WIDTH-1:0]         instr,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  output logic [ADDR_WIDTH-1:0]         pc,
  output logic [DATA_WIDTH-1:0]         exec_instr,
  output logic                          exec_valid,
  output logic [DATA_WIDTH-1:0]         rs_data,
  output logic                          rs_push,
  output logic                          rs_pop,
  input  logic [DATA_WIDTH-1:0]         rs_q,
  output logic [$clog2(RS_DEPTH):0]     rs_depth,
  output logic                          halted,
  output logic                          fault,
  output logic [1:0]                    fault_code
);

  localparam int                     DEPTH_W   = $clog2(RS_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0]     DEPTH_MAX = DEPTH_W'(RS_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]  PC_RESET  = ADDR_WIDTH'(RESET_PC);

  localparam logic [1:0] OP_DATA = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;

  typedef enum logic [2:0] {
    S_RUN,
    S_CALL_WR,
    S_RET_RD,
    S_RET_POP,
    S_HALT,
    S_FAULT
  } state_t;

  state_t state;

  logic [1:0]              opcode;
  logic [DATA_WIDTH-3:0]   operand;
  logic [ADDR_WIDTH-1:0]   target;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic [DATA_WIDTH-1:0]   ret_addr;
  logic                    is_ret;
  logic                    is_halt;

  assign opcode   = instr[DATA_WIDTH-1 -: 2];
  assign operand  = instr[DATA_WIDTH-3:0];
  assign target   = instr[ADDR_WIDTH-1:0];
  assign pc_next  = pc + ADDR_WIDTH'(1);
  assign ret_addr = DATA_WIDTH'(pc_next);
  assign is_ret   = (operand == '0);
  assign is_halt  = (operand == (DATA_WIDTH-2)'(1));

  assign instr_ready = (state == S_RUN) && !hold;

  // Only the low ADDR_WIDTH bits of a stored return address are meaningful.
  generate
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_rs_q_high
      logic unused_rs_q_high;
      assign unused_rs_q_high = ^rs_q[DATA_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  always_ff @(posedge write_clock) begin
    if (reset) begin
      state      <= S_RUN;
      pc         <= PC_RESET;
      rs_depth   <= '0;
      exec_instr <= '0;
      exec_valid <= 1'b0;
      rs_data    <= '0;
      rs_push    <= 1'b0;
      rs_pop     <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      exec_valid <= 1'b0;
      rs_push    <= 1'b0;
      rs_pop     <= 1'b0;
      if (!hold) begin
        case (state)
          S_RUN: begin
            if (instr_valid) begin
              case (opcode)
                OP_DATA: begin
                  exec_instr <= instr;
                  exec_valid <= 1'b1;
                  pc         <= pc_next;
                end
                OP_JMP: begin
                  pc <= target;
                end
                OP_CALL: begin
                  if (rs_depth < DEPTH_MAX) begin
                    rs_data <= ret_addr;
                    pc      <= target;
                    state   <= S_CALL_WR;
                  end else begin
                    fault      <= 1'b1;
                    fault_code <= FC_OVERFLOW;
                    state      <= S_FAULT;
                  end
                end
                default: begin
                  if (is_ret) begin
                    if (rs_depth != '0) begin
                      state <= S_RET_RD;
                    end else begin
                      fault      <= 1'b1;
                      fault_code <= FC_UNDERFLOW;
                      state      <= S_FAULT;
                    end
                  end else if (is_halt) begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                  end else begin
                    exec_instr <= instr;
                    exec_valid <= 1'b1;
                    pc         <= pc_next;
                  end
                end
              endcase
            end
          end
          S_CALL_WR: begin
            rs_push  <= 1'b1;
            rs_depth <= rs_depth + DEPTH_W'(1);
            state    <= S_RUN;
          end
          // rs_q is registered by the stack, so give it a cycle to settle on the top entry.
          S_RET_RD: begin
            state <= S_RET_POP;
          end
          S_RET_POP: begin
            pc       <= rs_q[ADDR_WIDTH-1:0];
            rs_pop   <= 1'b1;
            rs_depth <= rs_depth - DEPTH_W'(1);
            state    <= S_RUN;
          end
          S_HALT: begin
            state <= S_HALT;
          end
          S_FAULT: begin
            state <= S_FAULT;
          end
          default: begin
            state <= S_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_return_sequencer.sv
// Self-checking bench for return_sequencer: vector table for straight-line code, hand sequences for call/return corners.
module tb_return_sequencer;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int RSD  = 4;
  localparam int DEPW = $clog2(RSD) + 1;

  logic            write_clock;
  logic            reset;
  logic            hold;
  logic [DW-1:0]   instr;
  logic            instr_valid;
  logic            instr_ready;
  logic [AW-1:0]   pc;
  logic [DW-1:0]   exec_instr;
  logic            exec_valid;
  logic [DW-1:0]   rs_data;
  logic            rs_push;
  logic            rs_pop;
  logic [DW-1:0]   rs_q;
  logic [DEPW-1:0] rs_depth;
  logic            halted;
  logic            fault;
  logic [1:0]      fault_code;

  return_sequencer #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RS_DEPTH(RSD),
    .RESET_PC(0)
  ) dut (
    .write_clock(write_clock),
    .reset(reset),
    .hold(hold),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc(pc),
    .exec_instr(exec_instr),
    .exec_valid(exec_valid),
    .rs_data(rs_data),
    .rs_push(rs_push),
    .rs_pop(rs_pop),
    .rs_q(rs_q),
    .rs_depth(rs_depth),
    .halted(halted),
    .fault(fault),
    .fault_code(fault_code)
  );

  initial write_clock = 1'b0;
  always #5 write_clock = ~write_clock;

  int checks = 0;
  int failures = 0;
  int push_count = 0;
  int pop_count = 0;

  logic [DW-1:0] exp_exec_q[$];
  logic [DW-1:0] exp_push_q[$];
  logic [DW-1:0] stk[$];
  logic [DW-1:0] mon_exp;

  typedef struct {
    logic [DW-1:0] instr;
    logic [AW-1:0] exp_pc;
    logic          is_data;
  } vec_t;

  vec_t vecs[8];

  // Return-stack model with a registered top-of-stack output; also tallies strobes.
  always @(posedge write_clock) begin
    if (rs_push) push_count++;
    if (rs_pop) pop_count++;
    if (reset) begin
      stk.delete();
      rs_q <= '0;
    end else begin
      if (rs_push) stk.push_back(rs_data);
      else if (rs_pop && stk.size() > 0) void'(stk.pop_back());
      rs_q <= (stk.size() > 0) ? stk[$] : '0;
    end
  end

  // Scoreboard: every exec or push strobe must match the next expected word.
  always @(negedge write_clock) begin
    if (exec_valid) begin
      checks++;
      if (exp_exec_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL exec_unexpected: got %h, none expected", exec_instr);
      end else begin
        mon_exp = exp_exec_q.pop_front();
        if (exec_instr !== mon_exp) begin
          failures++;
          $display("[TB] FAIL exec_instr: got %h, expected %h", exec_instr, mon_exp);
        end
      end
    end
    if (rs_push) begin
      checks++;
      if (exp_push_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL push_unexpected: got rs_data %h, no push expected", rs_data);
      end else begin
        mon_exp = exp_push_q.pop_front();
        if (rs_data !== mon_exp) begin
          failures++;
          $display("[TB] FAIL push_data: got %h, expected %h", rs_data, mon_exp);
        end
      end
    end
    if (rs_push || rs_pop) begin
      checks++;
      if (rs_push && rs_pop) begin
        failures++;
        $display("[TB] FAIL push_pop_overlap: got push=%b pop=%b, expected not both", rs_push, rs_pop);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer one word and wait until it is accepted; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [DW-1:0] w);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge write_clock);
      n++;
    end
    if (!instr_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got instr_ready=0, expected 1 for word %h", w);
    end else begin
      instr = w;
      instr_valid = 1'b1;
      @(posedge write_clock);
      @(negedge write_clock);
      instr_valid = 1'b0;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge write_clock);
    @(negedge write_clock);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0005, 10'h001, 1'b1};
    vecs[1] = '{16'h0123, 10'h002, 1'b1};
    vecs[2] = '{16'hC005, 10'h003, 1'b1};
    vecs[3] = '{16'h4100, 10'h100, 1'b0};
    vecs[4] = '{16'h3FFF, 10'h101, 1'b1};
    vecs[5] = '{16'h43FF, 10'h3FF, 1'b0};
    vecs[6] = '{16'h0007, 10'h000, 1'b1};
    vecs[7] = '{16'h4003, 10'h003, 1'b0};

    reset = 1'b1;
    hold = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    repeat (2) @(posedge write_clock);
    @(negedge write_clock);
    checkOutput("reset_pc", pc, 0);
    checkOutput("reset_depth", rs_depth, 0);
    checkOutput("reset_strobes", {exec_valid, rs_push, rs_pop}, 0);
    checkOutput("reset_exec_instr", exec_instr, 0);
    checkOutput("reset_rs_data", rs_data, 0);
    checkOutput("reset_status", {halted, fault, fault_code}, 0);
    reset = 1'b0;
    @(negedge write_clock);
    checkOutput("run_ready", instr_ready, 1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_data) exp_exec_q.push_back(vecs[i].instr);
      applyStimulus(vecs[i].instr);
      checkOutput($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      checkOutput($sformatf("vec%0d_exec_valid", i), exec_valid, vecs[i].is_data);
      checkOutput($sformatf("vec%0d_rs_strobes", i), {rs_push, rs_pop}, 0);
      checkOutput($sformatf("vec%0d_depth", i), rs_depth, 0);
    end

    // CALL from pc=3, then RET through the model stack.
    exp_push_q.push_back(16'h0004);
    applyStimulus(16'h8040);
    checkOutput("call_pc", pc, 10'h040);
    checkOutput("call_rs_data", rs_data, 16'h0004);
    checkOutput("call_wr_no_push_yet", rs_push, 0);
    @(negedge write_clock);
    checkOutput("call_push", rs_push, 1);
    checkOutput("call_depth", rs_depth, 1);
    applyStimulus(16'hC000);
    checkOutput("ret_rd_no_pop", rs_pop, 0);
    checkOutput("ret_rd_pc", pc, 10'h040);
    @(negedge write_clock);
    checkOutput("ret_popst_no_pop", rs_pop, 0);
    @(negedge write_clock);
    checkOutput("ret_pop", rs_pop, 1);
    checkOutput("ret_pc", pc, 10'h004);
    checkOutput("ret_depth", rs_depth, 0);

    // RET held in RET_POP for three cycles.
    exp_push_q.push_back(16'h0005);
    applyStimulus(16'h8200);
    @(negedge write_clock);
    applyStimulus(16'hC000);
    @(negedge write_clock);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge write_clock);
      checkOutput($sformatf("hold%0d_no_pop", c), rs_pop, 0);
      checkOutput($sformatf("hold%0d_pc", c), pc, 10'h200);
    end
    hold = 1'b0;
    @(negedge write_clock);
    checkOutput("hold_release_pop", rs_pop, 1);
    checkOutput("hold_release_pc", pc, 10'h005);
    checkOutput("hold_release_depth", rs_depth, 0);
    @(negedge write_clock);
    checkOutput("hold_single_pop", rs_pop, 0);
    checkOutput("pop_count_after_hold", pop_count, 2);
    hold = 1'b1;
    @(negedge write_clock);
    checkOutput("hold_run_not_ready", instr_ready, 0);
    hold = 1'b0;

    // Jump to the top of memory, CALL whose return address wraps to zero.
    applyStimulus(16'h43FF);
    checkOutput("jmp_top_pc", pc, 10'h3FF);
    exp_push_q.push_back(16'h0000);
    applyStimulus(16'h8010);
    checkOutput("wrap_call_pc", pc, 10'h010);
    checkOutput("wrap_rs_data", rs_data, 16'h0000);
    @(negedge write_clock);
    checkOutput("wrap_push", rs_push, 1);
    checkOutput("wrap_depth", rs_depth, 1);

    // Reset while in CALL_WR must abort the push.
    applyStimulus(16'h8020);
    reset = 1'b1;
    @(posedge write_clock);
    @(negedge write_clock);
    reset = 1'b0;
    checkOutput("abort_no_push", rs_push, 0);
    checkOutput("abort_pc", pc, 0);
    checkOutput("abort_depth", rs_depth, 0);
    @(negedge write_clock);
    checkOutput("push_count_after_abort", push_count, 3);

    // Nested CALLs until the stack is full; the fifth faults.
    for (int k = 1; k <= 4; k++) begin
      exp_push_q.push_back(16'((k - 1) * 16'h10 + 1));
      applyStimulus(16'h8000 | 16'(k * 16'h10));
      @(negedge write_clock);
    end
    checkOutput("full_depth", rs_depth, 4);
    applyStimulus(16'h8050);
    checkOutput("ovf_fault", fault, 1);
    checkOutput("ovf_code", fault_code, 2'b01);
    checkOutput("ovf_pc", pc, 10'h040);
    for (int c = 0; c < 3; c++) begin
      @(negedge write_clock);
      checkOutput($sformatf("ovf%0d_not_ready", c), instr_ready, 0);
    end
    checkOutput("push_count_after_ovf", push_count, 7);

    // RET on an empty stack faults without popping.
    doReset();
    applyStimulus(16'hC000);
    checkOutput("udf_fault", fault, 1);
    checkOutput("udf_code", fault_code, 2'b10);
    checkOutput("udf_pc", pc, 0);
    repeat (3) @(negedge write_clock);
    checkOutput("udf_pop_count", pop_count, 2);
    checkOutput("udf_not_ready", instr_ready, 0);

    // HALT is absorbing.
    doReset();
    checkOutput("reset_clears_fault", {fault, fault_code}, 0);
    applyStimulus(16'hC001);
    checkOutput("halt_flag", halted, 1);
    checkOutput("halt_no_fault", fault, 0);
    @(negedge write_clock);
    checkOutput("halt_not_ready", instr_ready, 0);

    checkOutput("exec_queue_drained", exp_exec_q.size(), 0);
    checkOutput("push_queue_drained", exp_push_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
